// File: rtl/rv32_issue_scoreboard.sv
// Issue scoreboard between rv32 decode and execute: per-register pending-write counters plus one issue slot.
// Latency: decode accept -> iss_valid 1 cycle; writeback clears a hazard for the next cycle (same cycle with bypass).
// Backpressure: dec_ready drops on RAW hazard, counter saturation, flush, reset, or a full issue slot not being taken.
//
// Optional feature macro: RV32_SCOREBOARD_WB_BYPASS_EN (same-cycle writeback forwarding relaxes hazard/sat).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   dec_*                     decoded instruction handshake and register fields
//   iss_valid/iss_ready       issue slot handshake toward execute; iss_rd/iss_writes_rd slot contents
//   wb_valid/wb_rd            one retiring register write per cycle
//   flush                     synchronous clear of pending state and issue slot
//   busy, wb_error            status: anything outstanding; sticky retirement-underflow flag
module rv32_issue_scoreboard #(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    output logic       dec_ready,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic [4:0] dec_rd,
    input  logic       dec_uses_rs1,
    input  logic       dec_uses_rs2,
    input  logic       dec_writes_rd,
    output logic       iss_valid,
    input  logic       iss_ready,
    output logic [4:0] iss_rd,
    output logic       iss_writes_rd,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       flush,
    output logic       busy,
    output logic       wb_error
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    // Storage only for x1..x31; x0 reads as zero through cnt_rd.
    logic [COUNTER_WIDTH-1:0] cnt    [1:31];
    logic [COUNTER_WIDTH-1:0] cnt_rd [0:31];

    logic        hazard;
    logic        sat;
    logic        slot_free;
    logic        accept;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        rd_full;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;
    logic        err_set;

    always_comb begin
        cnt_rd[0] = '0;
        for (int i = 1; i < 32; i++) begin
            cnt_rd[i] = cnt[i];
        end
    end

    assign rs1_pending = dec_uses_rs1 && (cnt_rd[dec_rs1] != '0);
    assign rs2_pending = dec_uses_rs2 && (cnt_rd[dec_rs2] != '0);
    assign rd_full     = dec_writes_rd && (cnt_rd[dec_rd] == CNT_MAX);

`ifdef RV32_SCOREBOARD_WB_BYPASS_EN
    // A source whose only outstanding write retires this cycle is forwarded by
    // writeback, so it is not a hazard. A full rd being retired this cycle nets
    // to no change, so it cannot overflow either.
    logic rs1_byp;
    logic rs2_byp;
    logic rd_byp;
    assign rs1_byp = wb_valid && (wb_rd == dec_rs1) && (cnt_rd[dec_rs1] == CNT_ONE);
    assign rs2_byp = wb_valid && (wb_rd == dec_rs2) && (cnt_rd[dec_rs2] == CNT_ONE);
    assign rd_byp  = wb_valid && (wb_rd == dec_rd);
    assign hazard  = (rs1_pending && !rs1_byp) || (rs2_pending && !rs2_byp);
    assign sat     = rd_full && !rd_byp;
`else
    assign hazard  = rs1_pending || rs2_pending;
    assign sat     = rd_full;
`endif

    assign slot_free = !iss_valid || iss_ready;
    assign dec_ready = !rst && !flush && slot_free && !hazard && !sat;
    assign accept    = dec_valid && dec_ready;

    // One-hot increment/decrement selects; bit 0 is never set so x0 stays untracked.
    assign inc_vec = (accept && dec_writes_rd && (dec_rd != 5'd0)) ? (32'd1 << dec_rd) : 32'd0;
    assign dec_vec = (wb_valid && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;

    // Retiring a register with nothing outstanding is an error unless it is
    // being claimed again in the same cycle (net unchanged).
    assign err_set = dec_vec[wb_rd] && (cnt_rd[wb_rd] == '0) && !inc_vec[wb_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                cnt[i] <= '0;
            end
            wb_error <= 1'b0;
        end else if (flush) begin
            for (int i = 1; i < 32; i++) begin
                cnt[i] <= '0;
            end
            wb_error <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
            if (err_set) begin
                wb_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid     <= 1'b0;
            iss_rd        <= 5'd0;
            iss_writes_rd <= 1'b0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (accept) begin
            iss_valid     <= 1'b1;
            iss_rd        <= dec_rd;
            iss_writes_rd <= dec_writes_rd;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

    always_comb begin
        busy = iss_valid;
        for (int i = 1; i < 32; i++) begin
            busy = busy || (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_rv32_issue_scoreboard.sv
// Directed self-checking bench for rv32_issue_scoreboard.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
// Expected values are hand-derived per step; bypass-dependent steps branch on the feature macro.
module tb_rv32_issue_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic       dec_ready;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [4:0] dec_rd;
    logic       dec_uses_rs1;
    logic       dec_uses_rs2;
    logic       dec_writes_rd;
    logic       iss_valid;
    logic       iss_ready;
    logic [4:0] iss_rd;
    logic       iss_writes_rd;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       flush;
    logic       busy;
    logic       wb_error;

    int nvec = 0;
    int nerr = 0;

    rv32_issue_scoreboard #(.COUNTER_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_writes_rd(dec_writes_rd),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd), .iss_writes_rd(iss_writes_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_writes_rd = 0;
        iss_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic dec_write(input logic [4:0] rd);
        dec_valid = 1; dec_rd = rd; dec_writes_rd = 1;
        dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_rs1 = 0; dec_rs2 = 0;
    endtask

    initial begin
        // Reset state, with a decode request already present.
        rst = 1;
        idle();
        dec_valid = 1;
        #2;
        chk("rst_dec_ready", dec_ready, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb_error", wb_error, 0);
        tick();
        tick();
        rst = 0;
        idle();

        // Single write to x5 issues one cycle after accept.
        dec_write(5'd5);
        iss_ready = 1;
        #1 chk("t1_dec_ready", dec_ready, 1);
        tick();
        #1;
        chk("t1_iss_valid", iss_valid, 1);
        chk("t1_iss_rd", iss_rd, 5);
        chk("t1_iss_wr", iss_writes_rd, 1);
        chk("t1_busy", busy, 1);

        // RAW on x5 stalls until retirement.
        dec_valid = 1; dec_writes_rd = 0; dec_rd = 0;
        dec_uses_rs1 = 1; dec_rs1 = 5'd5;
        #1 chk("raw_stall0", dec_ready, 0);
        tick();
        #1;
        chk("raw_stall1", dec_ready, 0);
        chk("raw_slot_drained", iss_valid, 0);
        chk("raw_busy_cnt", busy, 1);
        wb_valid = 1; wb_rd = 5'd5;
        #1;
`ifdef RV32_SCOREBOARD_WB_BYPASS_EN
        chk("raw_wb_cycle", dec_ready, 1);
        tick();
        wb_valid = 0;
        #1 chk("byp_issue", iss_valid, 1);
        dec_valid = 0;
`else
        chk("raw_wb_cycle", dec_ready, 0);
        tick();
        wb_valid = 0;
        #1;
        chk("raw_clear", dec_ready, 1);
        chk("raw_no_issue_yet", iss_valid, 0);
        tick();
        #1 chk("raw_issue", iss_valid, 1);
        chk("raw_issue_wr", iss_writes_rd, 0);
        dec_valid = 0;
`endif
        tick();
        #1;
        chk("raw_idle_valid", iss_valid, 0);
        chk("raw_idle_busy", busy, 0);

        // Saturation: three outstanding writes to x7 block a fourth.
        dec_write(5'd7);
        iss_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("sat_fill", dec_ready, 1);
            tick();
        end
        #1 chk("sat_block", dec_ready, 0);
        tick();
        wb_valid = 1; wb_rd = 5'd7;
        #1;
`ifdef RV32_SCOREBOARD_WB_BYPASS_EN
        chk("sat_wb_cycle", dec_ready, 1);
        tick();
        wb_valid = 0;
        #1 chk("sat_issue", iss_valid, 1);
`else
        chk("sat_wb_cycle", dec_ready, 0);
        tick();
        wb_valid = 0;
        #1 chk("sat_release", dec_ready, 1);
        tick();
        #1 chk("sat_issue", iss_valid, 1);
`endif
        dec_valid = 0;
        chk("sat_issue_rd", iss_rd, 7);
        wb_valid = 1; wb_rd = 5'd7;
        repeat (3) tick();
        wb_valid = 0;
        tick();
        #1;
        chk("sat_drain_busy", busy, 0);
        chk("sat_no_error", wb_error, 0);

        // Issue slot backpressure and back-to-back issue.
        dec_write(5'd10);
        iss_ready = 1;
        tick();
        iss_ready = 0;
        dec_write(5'd11);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_dec_ready", dec_ready, 0);
            chk("bp_iss_valid", iss_valid, 1);
            chk("bp_iss_rd", iss_rd, 10);
            tick();
        end
        iss_ready = 1;
        #1 chk("bp_release", dec_ready, 1);
        tick();
        #1;
        chk("b2b_rd11", iss_rd, 11);
        chk("b2b_valid11", iss_valid, 1);
        dec_write(5'd12);
        #1 chk("b2b_ready12", dec_ready, 1);
        tick();
        #1 chk("b2b_rd12", iss_rd, 12);
        dec_valid = 0;
        tick();
        #1;
        chk("b2b_drained", iss_valid, 0);
        chk("b2b_busy_cnt", busy, 1);

        // Retirement errors: x0 ignored, same-cycle inc/dec is neutral, underflow is sticky.
        wb_valid = 1; wb_rd = 5'd0;
        tick();
        #1 chk("wb_x0_no_err", wb_error, 0);
        dec_write(5'd13);
        wb_rd = 5'd13;
        #1 chk("incdec_ready", dec_ready, 1);
        tick();
        #1 chk("incdec_no_err", wb_error, 0);
        dec_valid = 0;
        wb_rd = 5'd9;
        tick();
        wb_valid = 0;
        #1 chk("wb_underflow", wb_error, 1);
        tick();
        #1 chk("wb_err_sticky", wb_error, 1);

        // Flush clears counters, slot and error; accept suppressed.
        dec_write(5'd14);
        flush = 1;
        #1 chk("flush_dec_ready", dec_ready, 0);
        tick();
        flush = 0;
        dec_valid = 0;
        #1;
        chk("flush_err", wb_error, 0);
        chk("flush_busy", busy, 0);
        chk("flush_iss_valid", iss_valid, 0);

        // Asynchronous reset mid-stream with x3 count 2 and the slot full.
        dec_write(5'd3);
        iss_ready = 1;
        tick();
        tick();
        dec_valid = 0;
        iss_ready = 0;
        #1;
        chk("pre_rst_valid", iss_valid, 1);
        chk("pre_rst_rd", iss_rd, 3);
        #1 rst = 1;
        #1;
        chk("arst_iss_valid", iss_valid, 0);
        chk("arst_iss_rd", iss_rd, 0);
        chk("arst_iss_wr", iss_writes_rd, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dec_ready", dec_ready, 0);
        tick();
        rst = 0;
        #1;
        chk("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
